fft_bitrev_feeder: RTL and testbench

Input stage of the radix-2 DIT FFT: collects one frame of N complex time-domain samples from a valid/ready stream and stores each at its bit-reversed address. It then presents the N/2 first-stage operand pairs (u, v) plus the stage-1 twiddle (W0 = 1.0) to the downstream `butterfly`. Capture and drain do not overlap: single-buffered, one frame in flight.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_bitrev_feeder_if.sv | 44 ++++
 rtl/fft_bitrev_feeder.sv | 98 +++++++++
 tb/tb_fft_bitrev_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default word format, the feeder state encoding and
// the bit-reversal helper used by every address generator in the datapath.
package fft_pkg;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_FRACTION = 8;
  localparam int DEF_N        = 8;

  // FILL collects a frame, DRAIN presents first-stage butterfly pairs.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Reverse the low nbits bits of value; bits above nbits come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] value, input int nbits);
    logic [15:0] result;
    result = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < nbits) result[b] = value[nbits-1-b];
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_bitrev_feeder_if.sv
// Sample stream in, butterfly operand stream out, for the bit-reversal feeder.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its data
// stable until that edge. Ready never depends combinationally on valid.
interface fft_bitrev_feeder_if
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
);
  localparam int LOGN = $clog2(N);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] u_re;
  logic signed [WIDTH-1:0] u_im;
  logic signed [WIDTH-1:0] v_re;
  logic signed [WIDTH-1:0] v_im;
  logic signed [WIDTH-1:0] w_re;
  logic signed [WIDTH-1:0] w_im;
  logic [LOGN-2:0]         pair_idx;
  logic                    out_last;

  // Environment side: supplies samples and consumes operand pairs.
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, u_re, u_im, v_re, v_im, w_re, w_im,
           pair_idx, out_last
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, u_re, u_im, v_re, v_im, w_re, w_im,
           pair_idx, out_last
  );

endinterface

// File: rtl/fft_bitrev_feeder.sv
// FFT input stage: stores one frame of N complex samples at bit-reversed
// addresses, then hands out the N/2 first-stage pairs (buf[2k], buf[2k+1])
// with the trivial stage-1 twiddle. Single buffered: fill, then drain.
module fft_bitrev_feeder
  import fft_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRACTION = DEF_FRACTION,
  parameter int N        = DEF_N
) (
  input  logic   clk,
  input  logic   rst,
  fft_bitrev_feeder_if.slave bus,
  output state_t dbg_state
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] I_LAST = {LOGN{1'b1}};
  localparam logic [LOGN-2:0] K_LAST = {(LOGN-1){1'b1}};

  state_t state, state_next;
  logic [LOGN-1:0] i_cnt;
  logic [LOGN-2:0] k_cnt;

  logic signed [WIDTH-1:0] mem_re [N];
  logic signed [WIDTH-1:0] mem_im [N];

  logic            accept;
  logic            take;
  logic [LOGN-1:0] wr_addr;
  logic [LOGN-1:0] rd_addr_u;
  logic [LOGN-1:0] rd_addr_v;

  assign accept    = (state == FILL) && bus.in_valid;
  assign take      = (state == DRAIN) && bus.out_ready;
  assign wr_addr   = LOGN'(bitrev(16'(i_cnt), LOGN));
  assign rd_addr_u = {k_cnt, 1'b0};
  assign rd_addr_v = {k_cnt, 1'b1};

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next state: leave FILL on the last sample, leave DRAIN on the last pair.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && (i_cnt == I_LAST)) state_next = DRAIN;
      DRAIN:   if (take && (k_cnt == K_LAST))   state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Sample and pair counters; both wrap to zero at the end of their phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= '0;
      k_cnt <= '0;
    end else begin
      if (accept) i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
      if (take)   k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
    end
  end

  // Frame buffer: each accepted sample lands at its bit-reversed address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        mem_re[j] <= '0;
        mem_im[j] <= '0;
      end
    end else if (accept) begin
      mem_re[wr_addr] <= bus.in_re;
      mem_im[wr_addr] <= bus.in_im;
    end
  end

  // Handshake flags decode the registered state only.
  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == DRAIN);

  // Operands are plain reads of registered storage at the current pair index.
  assign bus.u_re     = mem_re[rd_addr_u];
  assign bus.u_im     = mem_im[rd_addr_u];
  assign bus.v_re     = mem_re[rd_addr_v];
  assign bus.v_im     = mem_im[rd_addr_v];
  assign bus.pair_idx = k_cnt;
  assign bus.out_last = (state == DRAIN) && (k_cnt == K_LAST);

  // Stage-1 twiddle is W0 = 1.0 in Q(WIDTH-FRACTION).FRACTION.
  assign bus.w_re = WIDTH'(1) << FRACTION;
  assign bus.w_im = '0;

  assign dbg_state = state;

endmodule

// File: tb/tb_fft_bitrev_feeder.sv
// Directed bench for fft_bitrev_feeder (N = 8, WIDTH = 12, FRACTION = 8).
module tb_fft_bitrev_feeder;
  import fft_pkg::*;

  localparam int WIDTH = 12;
  localparam int N     = 8;
  localparam int LOGN  = 3;
  localparam int W     = 4*WIDTH + (LOGN-1) + 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  fft_bitrev_feeder_if #(.WIDTH(WIDTH), .N(N)) bus ();

  fft_bitrev_feeder #(.WIDTH(WIDTH), .FRACTION(8), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  // ---------------- model + scoreboard ----------------
  logic [W-1:0]       exp_q[$];
  logic [WIDTH-1:0]   fr_re[$];
  logic [WIDTH-1:0]   fr_im[$];
  bit                 model_drain = 0;
  logic [WIDTH-1:0]   got_u_re[$], got_u_im[$], got_v_re[$], got_v_im[$];
  logic [WIDTH-1:0]   got_idx[$], got_last[$];

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < LOGN; b++) begin
      r = r*2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Sample i is stored at rev(i), so slot s holds sample rev(s):
  // pair k is (x[rev(2k)], x[rev(2k+1)]).
  task automatic build_pairs();
    int a, b;
    for (int k = 0; k < N/2; k++) begin
      a = rev(2*k);
      b = rev(2*k+1);
      exp_q.push_back({fr_re[a], fr_im[a], fr_re[b], fr_im[b],
                       (LOGN-1)'(k), (k == N/2-1) ? 1'b1 : 1'b0});
    end
  endtask

  // Compare process: outputs are checked mid-cycle, then the handshakes about
  // to happen on the next edge advance the model.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete(); fr_re.delete(); fr_im.delete();
      model_drain = 0;
      check("rst_in_ready",  {11'b0, bus.in_ready},  12'd1);
      check("rst_out_valid", {11'b0, bus.out_valid}, 12'd0);
      check("rst_u_re", bus.u_re, 12'd0);
      check("rst_v_re", bus.v_re, 12'd0);
      check("rst_out_last", {11'b0, bus.out_last}, 12'd0);
    end else begin
      check("out_valid", {11'b0, bus.out_valid}, {11'b0, model_drain});
      check("in_ready",  {11'b0, bus.in_ready},  {11'b0, !model_drain});
      check("dbg_state", {11'b0, dbg_state == DRAIN}, {11'b0, model_drain});
      check("w_re", bus.w_re, 12'd256);
      check("w_im", bus.w_im, 12'd0);
      if (model_drain) begin
        e = exp_q[0];
        check("u_re", bus.u_re, e[50:39]);
        check("u_im", bus.u_im, e[38:27]);
        check("v_re", bus.v_re, e[26:15]);
        check("v_im", bus.v_im, e[14:3]);
        check("pair_idx", {10'b0, bus.pair_idx}, {10'b0, e[2:1]});
        check("out_last", {11'b0, bus.out_last}, {11'b0, e[0]});
        if (bus.out_ready) begin
          got_u_re.push_back(bus.u_re); got_u_im.push_back(bus.u_im);
          got_v_re.push_back(bus.v_re); got_v_im.push_back(bus.v_im);
          got_idx.push_back({10'b0, bus.pair_idx});
          got_last.push_back({11'b0, bus.out_last});
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) model_drain = 0;
        end
      end else if (bus.in_valid) begin
        fr_re.push_back(bus.in_re);
        fr_im.push_back(bus.in_im);
        if (fr_re.size() == N) begin
          build_pairs();
          fr_re.delete(); fr_im.delete();
          model_drain = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [WIDTH-1:0] src_re[N];
  logic [WIDTH-1:0] src_im[N];

  task automatic clear_logs();
    got_u_re.delete(); got_u_im.delete(); got_v_re.delete(); got_v_im.delete();
    got_idx.delete(); got_last.delete();
  endtask

  task automatic send_samples(input int n, input bit gaps);
    int  sent   = 0;
    int  budget = 0;
    bit  acc;
    while (sent < n) begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_re    = src_re[sent];
        bus.in_im    = src_im[sent];
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      budget++;
      if (budget > 200) begin
        timeout_fail("send_samples");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_pairs(input int n);
    int got    = 0;
    int budget = 0;
    bit hs;
    while (got < n) begin
      @(negedge clk);
      hs = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (hs) got++;
      budget++;
      if (budget > 200) begin
        timeout_fail("wait_pairs");
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, no stalls.
    for (int i = 0; i < N; i++) begin
      src_re[i] = WIDTH'(i*16);
      src_im[i] = WIDTH'(-i*16);
    end
    clear_logs();
    send_samples(N, 1'b0);
    check("first_valid_latency", {11'b0, bus.out_valid}, 12'd1);
    wait_pairs(N/2);
    check("t1_ready_after_last", {11'b0, bus.in_ready}, 12'd1);
    check("t1_u0_re", got_u_re[0], 12'd0);   check("t1_v0_re", got_v_re[0], 12'd64);
    check("t1_u1_re", got_u_re[1], 12'd32);  check("t1_v1_re", got_v_re[1], 12'd96);
    check("t1_u2_re", got_u_re[2], 12'd16);  check("t1_v2_re", got_v_re[2], 12'd80);
    check("t1_u3_re", got_u_re[3], 12'd48);  check("t1_v3_re", got_v_re[3], 12'd112);
    check("t1_u1_im", got_u_im[1], 12'hFE0); check("t1_v3_im", got_v_im[3], 12'hF90);
    check("t1_idx3", got_idx[3], 12'd3);
    check("t1_last2", got_last[2], 12'd0);   check("t1_last3", got_last[3], 12'd1);

    // Stall at k = 1 while in_valid pulses.
    send_samples(N, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c % 2 == 0);
      check("stall_u_re", bus.u_re, 12'd32);
      check("stall_v_re", bus.v_re, 12'd96);
      check("stall_idx", {10'b0, bus.pair_idx}, 12'd1);
      check("stall_valid", {11'b0, bus.out_valid}, 12'd1);
      check("stall_in_ready", {11'b0, bus.in_ready}, 12'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_pairs(N/2 - 1);

    // Random gaps during fill; same pair order expected.
    clear_logs();
    send_samples(N, 1'b1);
    check("gap_first_valid", {11'b0, bus.out_valid}, 12'd1);
    wait_pairs(N/2);
    check("gap_u2_re", got_u_re[2], 12'd16);
    check("gap_v1_re", got_v_re[1], 12'd96);

    // Back-to-back frames.
    clear_logs();
    send_samples(N, 1'b0);
    wait_pairs(N/2);
    check("b2b_ready_after_last", {11'b0, bus.in_ready}, 12'd1);
    for (int i = 0; i < N; i++) begin
      src_re[i] = WIDTH'(100 + i);
      src_im[i] = WIDTH'(-(100 + i));
    end
    send_samples(N, 1'b0);
    wait_pairs(N/2);
    check("f2_u0_re", got_u_re[4], 12'd100); check("f2_v0_re", got_v_re[4], 12'd104);
    check("f2_u1_re", got_u_re[5], 12'd102); check("f2_v1_re", got_v_re[5], 12'd106);
    check("f2_u2_re", got_u_re[6], 12'd101); check("f2_v2_re", got_v_re[6], 12'd105);
    check("f2_u3_re", got_u_re[7], 12'd103); check("f2_v3_re", got_v_re[7], 12'd107);

    // Reset after 5 accepted samples.
    for (int i = 0; i < N; i++) begin
      src_re[i] = WIDTH'(300 + i);
      src_im[i] = WIDTH'(400 + i);
    end
    send_samples(5, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_now_in_ready", {11'b0, bus.in_ready}, 12'd1);
    check("rst_now_out_valid", {11'b0, bus.out_valid}, 12'd0);
    check("rst_now_u_re", bus.u_re, 12'd0);
    check("rst_now_v_im", bus.v_im, 12'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      src_re[i] = WIDTH'(7*i + 1);
      src_im[i] = WIDTH'(50 - i);
    end
    clear_logs();
    send_samples(N, 1'b0);
    wait_pairs(N/2);
    check("post_rst_u0_re", got_u_re[0], 12'd1);
    check("post_rst_v0_re", got_v_re[0], 12'd29);
    check("post_rst_v3_im", got_v_im[3], 12'd43);

    // Extreme values.
    for (int i = 0; i < N; i++) begin
      src_re[i] = (i % 2 == 0) ? 12'h7FF : 12'h800;
      src_im[i] = (i % 2 == 0) ? 12'h800 : 12'h7FF;
    end
    clear_logs();
    send_samples(N, 1'b0);
    wait_pairs(N/2);
    check("ext_u0_re", got_u_re[0], 12'h7FF); check("ext_u0_im", got_u_im[0], 12'h800);
    check("ext_u2_re", got_u_re[2], 12'h800); check("ext_v2_im", got_v_im[2], 12'h7FF);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
